multi_debounce: RTL and testbench

//  N-channel button/switch conditioner; next generation of the single-channel Moore debouncer.
//  Per channel: 2-flop synchroniser, programmable stable-time filter, press/release/long-press pulses.

---
 rtl/multi_debounce.sv | 157 +++++++++++++++
 tb/tb_multi_debounce.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// N-channel push-button conditioner: 2-flop synchroniser, stable-time filter,
// and single-cycle press / release / long-press events per channel.
module multi_debounce #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned LONG_CYC    = 0,
    parameter int unsigned ACTIVE_HIGH = 1
) (
    input  logic            CLK_FPGA,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN,
    output logic [N_CH-1:0] LEVEL,
    output logic [N_CH-1:0] PRESS,
    output logic [N_CH-1:0] RELEASE,
    output logic [N_CH-1:0] LONG
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_P,
        PRESSED,
        DEB_R
    } deb_state_t;

    localparam int unsigned     CW       = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYC - 1);
    localparam logic [N_CH-1:0] PIN_IDLE = (ACTIVE_HIGH != 0) ? '0 : '1;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] btn_s;

    // Sync flops reset to the idle pin level so leaving reset never looks like a press.
    always_ff @(posedge CLK_FPGA or posedge RST) begin
        if (RST) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    assign btn_s = (ACTIVE_HIGH != 0) ? sync2 : ~sync2;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        deb_state_t    state;
        deb_state_t    state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          level_nxt;
        logic          press_nxt;
        logic          release_nxt;

        always_ff @(posedge CLK_FPGA or posedge RST) begin
            if (RST) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            unique case (state)
                IDLE: begin
                    if (btn_s[g]) begin
                        state_nxt = DEB_P;
                        cnt_nxt   = CW'(1);
                    end
                end
                DEB_P: begin
                    if (!btn_s[g]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        press_nxt = 1'b1;
                        level_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s[g]) begin
                        state_nxt = DEB_R;
                        cnt_nxt   = CW'(1);
                    end
                end
                DEB_R: begin
                    if (btn_s[g]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign LEVEL[g]   = level_q;
        assign PRESS[g]   = press_q;
        assign RELEASE[g] = release_q;

        if (LONG_CYC > 0) begin : g_long
            localparam int unsigned   HW        = $clog2(LONG_CYC + 1);
            localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

            logic [HW-1:0] hold;
            logic          long_q;
            logic          hold_run;

            // Hold only advances while settled in PRESSED; DEB_R freezes it.
            assign hold_run = (state == PRESSED) && btn_s[g];

            always_ff @(posedge CLK_FPGA or posedge RST) begin
                if (RST) begin
                    hold   <= '0;
                    long_q <= 1'b0;
                end else begin
                    long_q <= hold_run && (hold == HOLD_LAST);
                    if (press_nxt) begin
                        hold <= '0;
                    end else if (hold_run && (hold != HOLD_MAX)) begin
                        hold <= hold + HW'(1);
                    end
                end
            end

            assign LONG[g] = long_q;
        end else begin : g_nolong
            assign LONG[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed button scenarios plus random pin activity,
// checked every cycle against a run-length reference model.
module tb_multi_debounce;

    localparam int unsigned NCH = 4;
    localparam int unsigned SA  = 4;
    localparam int unsigned LA  = 10;
    localparam int unsigned SB  = 4;
    localparam int unsigned LB  = 0;

    logic           CLK_FPGA = 1'b0;
    logic           RST      = 1'b1;
    logic [NCH-1:0] btn_a    = '0;
    logic [NCH-1:0] btn_b    = '1;
    logic [NCH-1:0] lvl_a, prs_a, rel_a, lng_a;
    logic [NCH-1:0] lvl_b, prs_b, rel_b, lng_b;

    always #5 CLK_FPGA = ~CLK_FPGA;

    multi_debounce #(
        .N_CH(NCH), .STABLE_CYC(SA), .LONG_CYC(LA), .ACTIVE_HIGH(1)
    ) dut_a (
        .CLK_FPGA(CLK_FPGA), .RST(RST), .BTN(btn_a),
        .LEVEL(lvl_a), .PRESS(prs_a), .RELEASE(rel_a), .LONG(lng_a)
    );

    multi_debounce #(
        .N_CH(NCH), .STABLE_CYC(SB), .LONG_CYC(LB), .ACTIVE_HIGH(0)
    ) dut_b (
        .CLK_FPGA(CLK_FPGA), .RST(RST), .BTN(btn_b),
        .LEVEL(lvl_b), .PRESS(prs_b), .RELEASE(rel_b), .LONG(lng_b)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned stab(input int d);
        return (d == 0) ? SA : SB;
    endfunction

    function automatic int unsigned lcyc(input int d);
        return (d == 0) ? LA : LB;
    endfunction

    // Reference: level flips once the synchronised pin has disagreed with it for
    // STABLE_CYC consecutive edges; hold counts undisturbed pressed edges.
    bit             m_s1  [2][NCH];
    bit             m_s2  [2][NCH];
    bit             m_lvl [2][NCH];
    int unsigned    m_run [2][NCH];
    int unsigned    m_hold[2][NCH];
    logic [NCH-1:0] e_lvl[2], e_prs[2], e_rel[2], e_lng[2];

    always @(posedge CLK_FPGA) begin
        bit bs;
        bit pin;
        for (int d = 0; d < 2; d++) begin
            e_prs[d] = '0;
            e_rel[d] = '0;
            e_lng[d] = '0;
            for (int c = 0; c < NCH; c++) begin
                if (RST) begin
                    m_s1[d][c]   = 1'b0;
                    m_s2[d][c]   = 1'b0;
                    m_lvl[d][c]  = 1'b0;
                    m_run[d][c]  = 0;
                    m_hold[d][c] = 0;
                end else begin
                    pin = (d == 0) ? btn_a[c] : btn_b[c];
                    bs  = m_s2[d][c];
                    m_s2[d][c] = m_s1[d][c];
                    m_s1[d][c] = (d == 0) ? pin : !pin;
                    if (bs != m_lvl[d][c]) begin
                        m_run[d][c]++;
                        if (m_run[d][c] == stab(d)) begin
                            m_lvl[d][c] = bs;
                            m_run[d][c] = 0;
                            if (bs) begin
                                e_prs[d][c]  = 1'b1;
                                m_hold[d][c] = 0;
                            end else begin
                                e_rel[d][c] = 1'b1;
                            end
                        end
                    end else begin
                        if (m_lvl[d][c] && m_run[d][c] == 0 && m_hold[d][c] < lcyc(d)) begin
                            m_hold[d][c]++;
                            if (m_hold[d][c] == lcyc(d)) e_lng[d][c] = 1'b1;
                        end
                        m_run[d][c] = 0;
                    end
                end
                e_lvl[d][c] = m_lvl[d][c];
            end
        end
    end

    int unsigned pc[2][NCH], rc[2][NCH], lc[2][NCH];

    always @(negedge CLK_FPGA) begin
        if (chk_en) begin
            check("a_level",   lvl_a, e_lvl[0]);
            check("a_press",   prs_a, e_prs[0]);
            check("a_release", rel_a, e_rel[0]);
            check("a_long",    lng_a, e_lng[0]);
            check("b_level",   lvl_b, e_lvl[1]);
            check("b_press",   prs_b, e_prs[1]);
            check("b_release", rel_b, e_rel[1]);
            check("b_long",    lng_b, e_lng[1]);
            for (int c = 0; c < NCH; c++) begin
                pc[0][c] += prs_a[c];
                rc[0][c] += rel_a[c];
                lc[0][c] += lng_a[c];
                pc[1][c] += prs_b[c];
                rc[1][c] += rel_b[c];
                lc[1][c] += lng_b[c];
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_FPGA);
        #1;
    endtask

    task automatic clr_cnt();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                pc[d][c] = 0;
                rc[d][c] = 0;
                lc[d][c] = 0;
            end
    endtask

    // Directed phases drive both DUTs with the same logical press pattern.
    task automatic pin(input int c, input bit v);
        btn_a[c] = v;
        btn_b[c] = !v;
    endtask

    initial begin
        int unsigned rate;
        RST = 1'b1;
        cyc(3);
        chk_en = 1'b1;
        check("rst_level", {lvl_a, lvl_b}, '0);
        check("rst_pulses", {prs_a, rel_a, lng_a, prs_b, rel_b, lng_b}, '0);

        // Leaving reset with idle pins: no events on either polarity.
        RST = 1'b0;
        clr_cnt();
        cyc(8);
        check("idle_b_events", pc[1][0] + pc[1][1] + rc[1][0] + rc[1][1], 0);
        check("idle_a_events", pc[0][0] + pc[0][1] + rc[0][0] + rc[0][1], 0);

        // Clean press on ch0, then release.
        clr_cnt();
        pin(0, 1'b1);
        cyc(20);
        check("t1_press", pc[0][0], 1);
        check("t1_level", lvl_a[0], 1'b1);
        check("t1_others", pc[0][1] + pc[0][2] + pc[0][3], 0);
        check("t5_press_b", pc[1][0], 1);
        pin(0, 1'b0);
        cyc(12);
        check("t1_release", rc[0][0], 1);

        // Press bounce on ch1.
        clr_cnt();
        pin(1, 1'b1); cyc(1);
        pin(1, 1'b0); cyc(1);
        pin(1, 1'b1); cyc(1);
        pin(1, 1'b0); cyc(1);
        pin(1, 1'b1); cyc(20);
        check("t2_press", pc[0][1], 1);
        pin(1, 1'b0); cyc(12);
        check("t2_release", rc[0][1], 1);

        // Release bounce on ch2.
        clr_cnt();
        pin(2, 1'b1); cyc(20);
        pin(2, 1'b0); cyc(2);
        pin(2, 1'b1); cyc(3);
        check("t3_level_held", lvl_a[2], 1'b1);
        pin(2, 1'b0); cyc(20);
        check("t3_press", pc[0][2], 1);
        check("t3_release", rc[0][2], 1);

        // Long press on ch3, twice.
        clr_cnt();
        pin(3, 1'b1); cyc(50);
        check("t4_long1", lc[0][3], 1);
        check("t4_long_off_b", lc[1][3], 0);
        pin(3, 1'b0); cyc(20);
        check("t4_release", rc[0][3], 1);
        pin(3, 1'b1); cyc(50);
        check("t4_long2", lc[0][3], 2);
        check("t4_press2", pc[0][3], 2);
        pin(3, 1'b0); cyc(20);

        // Asynchronous reset while ch0 is pressed.
        clr_cnt();
        pin(0, 1'b1); cyc(15);
        #2 RST = 1'b1;
        #1;
        check("t6_async_level", {lvl_a, lvl_b}, '0);
        check("t6_async_pulse", {prs_a, rel_a, lng_a, prs_b, rel_b, lng_b}, '0);
        cyc(2);
        RST = 1'b0;
        cyc(20);
        check("t6_repress", pc[0][0], 2);
        check("t6_no_release", rc[0][0] + rc[1][0], 0);
        pin(0, 1'b0); cyc(20);

        // Random pin activity with occasional resets; glitchy and calm stretches alternate.
        for (int blk = 0; blk < 6; blk++) begin
            rate = (blk % 2 == 0) ? 3 : 16;
            for (int k = 0; k < 500; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(rate - 1, 0) == 0) btn_a[c] = !btn_a[c];
                    if ($urandom_range(rate - 1, 0) == 0) btn_b[c] = !btn_b[c];
                end
                RST = ($urandom_range(399, 0) == 0);
                cyc(1);
            end
        end
        RST = 1'b0;
        cyc(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
